// File: rtl/digest_serializer_32to8b_pkg.sv
// Shared constants, FSM state type and byte-select helper for the digest serializer.
package digest_serializer_32to8b_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int unsigned DIGEST_WORDS   = 8;
    localparam int unsigned BYTES_PER_WORD = 4;

    // Big-endian byte pick: index 0 is the most significant byte.
    function automatic logic [7:0] word_byte(input logic [31:0] word, input logic [1:0] idx);
        logic [7:0] b;
        case (idx)
            2'd0:    b = word[31:24];
            2'd1:    b = word[23:16];
            2'd2:    b = word[15:8];
            default: b = word[7:0];
        endcase
        return b;
    endfunction

endpackage

// File: rtl/digest_serializer_32to8b_if.sv
// Word write port plus byte-wide valid/ready output stream of the digest serializer.
interface digest_serializer_32to8b_if;
    logic        wr_en;
    logic [2:0]  wr_addr;
    logic [31:0] wr_data;
    logic        start;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic        busy;
    logic        done;

    modport master (
        output wr_en, wr_addr, wr_data, start, out_ready,
        input  out_data, out_valid, busy, done
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, start, out_ready,
        output out_data, out_valid, busy, done
    );
endinterface

// File: rtl/digest_serializer_32to8b.sv
// Holds the final hash words and streams them out MSB-first, one byte per handshake.
module digest_serializer_32to8b
    import digest_serializer_32to8b_pkg::*;
#(
    parameter int unsigned NUM_WORDS = DIGEST_WORDS,
    parameter int unsigned CNT_W     = 5
) (
    input logic                      clk,
    input logic                      rst,
    digest_serializer_32to8b_if.slave bus
);

    localparam int unsigned      NUM_BYTES = NUM_WORDS * BYTES_PER_WORD;
    localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(NUM_BYTES - 1);

    state_t           state;
    logic [CNT_W-1:0] byte_cnt;
    logic [31:0]      words [NUM_WORDS];
    logic             valid_q;
    logic             busy_q;
    logic             done_q;
    logic             wr_ok;
    logic             handshake;
    logic [CNT_W-3:0] word_sel;
    logic [7:0]       byte_q;

    // Storage is writable only while idle, so a stream always sees a frozen digest.
    assign wr_ok     = bus.wr_en && (state == ST_IDLE) && (32'(bus.wr_addr) < NUM_WORDS);
    assign handshake = valid_q && bus.out_ready;
    assign word_sel  = byte_cnt[CNT_W-1:2];

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int unsigned i = 0; i < NUM_WORDS; i++) begin
                words[i] <= '0;
            end
        end else if (wr_ok) begin
            words[bus.wr_addr] <= bus.wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= ST_IDLE;
            byte_cnt <= '0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.start) begin
                        state    <= ST_SEND;
                        byte_cnt <= '0;
                        valid_q  <= 1'b1;
                        busy_q   <= 1'b1;
                    end
                end
                ST_SEND: begin
                    if (handshake) begin
                        if (byte_cnt == LAST_BYTE) begin
                            state    <= ST_DONE;
                            byte_cnt <= '0;
                            valid_q  <= 1'b0;
                            done_q   <= 1'b1;
                        end else begin
                            byte_cnt <= byte_cnt + 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    state  <= ST_IDLE;
                    done_q <= 1'b0;
                    busy_q <= 1'b0;
                end
                default: begin
                    state    <= ST_IDLE;
                    byte_cnt <= '0;
                    valid_q  <= 1'b0;
                    busy_q   <= 1'b0;
                    done_q   <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        byte_q = '0;
        if (valid_q) begin
            byte_q = word_byte(words[word_sel], byte_cnt[1:0]);
        end
    end

    assign bus.out_data  = byte_q;
    assign bus.out_valid = valid_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;

endmodule

// File: tb/tb_digest_serializer_32to8b.sv
// Randomised bench for the digest serializer: 8-word and 7-word instances share stimulus.
module tb_digest_serializer_32to8b;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        wr_en = 1'b0;
    logic [2:0]  wr_addr = '0;
    logic [31:0] wr_data = '0;
    logic        start = 1'b0;
    logic        out_ready = 1'b0;

    always #5 clk = ~clk;

    digest_serializer_32to8b_if if8 ();
    digest_serializer_32to8b_if if7 ();

    assign if8.wr_en = wr_en;   assign if7.wr_en = wr_en;
    assign if8.wr_addr = wr_addr; assign if7.wr_addr = wr_addr;
    assign if8.wr_data = wr_data; assign if7.wr_data = wr_data;
    assign if8.start = start;   assign if7.start = start;
    assign if8.out_ready = out_ready; assign if7.out_ready = out_ready;

    digest_serializer_32to8b #(.NUM_WORDS(8), .CNT_W(5)) dut8 (.clk(clk), .rst(rst), .bus(if8));
    digest_serializer_32to8b #(.NUM_WORDS(7), .CNT_W(5)) dut7 (.clk(clk), .rst(rst), .bus(if7));

    logic [7:0] o_data  [2];
    logic       o_valid [2];
    logic       o_busy  [2];
    logic       o_done  [2];
    assign o_data[0] = if8.out_data;   assign o_data[1] = if7.out_data;
    assign o_valid[0] = if8.out_valid; assign o_valid[1] = if7.out_valid;
    assign o_busy[0] = if8.busy;       assign o_busy[1] = if7.busy;
    assign o_done[0] = if8.done;       assign o_done[1] = if7.done;

    int checks = 0;
    int errors = 0;

    // Reference model: digest contents plus "streaming / done pending / idle" and bytes accepted.
    logic [31:0] mmem [2][8];
    bit          strm [2];
    bit          dued [2];
    int          pos  [2];
    int          nw   [2] = '{8, 7};
    int          done_cnt [2] = '{0, 0};
    logic [7:0]  rx8 [$];
    logic [7:0]  rx7 [$];
    logic [7:0]  m_byte;
    logic        m_valid, m_busy, m_done;

    logic [31:0] iv [8] = '{32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                            32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};

    task automatic check(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 40)
                $display("FAIL %s (NUM_WORDS=%0d) at %0t: got %h, expected %h", name, nw[d], $time, act, exp);
        end
    endtask

    initial begin
        @(posedge clk);
        forever begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                m_valid = strm[d];
                m_busy  = strm[d] || dued[d];
                m_done  = dued[d];
                m_byte  = strm[d] ? 8'(mmem[d][pos[d] / 4] >> (8 * (3 - pos[d] % 4))) : 8'h00;
                check("out_valid", d, 32'(o_valid[d]), 32'(m_valid));
                check("out_data",  d, 32'(o_data[d]),  32'(m_byte));
                check("busy",      d, 32'(o_busy[d]),  32'(m_busy));
                check("done",      d, 32'(o_done[d]),  32'(m_done));
                if (o_done[d] === 1'b1) done_cnt[d]++;
                if (o_valid[d] === 1'b1 && out_ready) begin
                    if (d == 0) rx8.push_back(o_data[d]);
                    else        rx7.push_back(o_data[d]);
                end
                if (!rst) begin
                    for (int i = 0; i < 8; i++) mmem[d][i] = '0;
                    strm[d] = 0; dued[d] = 0; pos[d] = 0;
                end else if (strm[d]) begin
                    if (out_ready) begin
                        pos[d]++;
                        if (pos[d] == 4 * nw[d]) begin
                            strm[d] = 0; dued[d] = 1; pos[d] = 0;
                        end
                    end
                end else if (dued[d]) begin
                    dued[d] = 0;
                end else begin
                    if (wr_en && int'(wr_addr) < nw[d]) mmem[d][wr_addr] = wr_data;
                    if (start) begin
                        strm[d] = 1; pos[d] = 0;
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] dt);
        wr_en = 1'b1; wr_addr = a; wr_data = dt;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic wait_idle(input int maxc);
        int c;
        c = 0;
        while ((if8.busy !== 1'b0 || if7.busy !== 1'b0) && c < maxc) begin
            tick();
            c++;
        end
        if (c >= maxc) begin
            checks++; errors++;
            $display("FAIL wait_idle: busy still high after %0d cycles (busy8=%b busy7=%b), expected 0",
                     maxc, if8.busy, if7.busy);
        end
    endtask

    task automatic run_stream(input bit rnd);
        int c;
        rx8.delete(); rx7.delete();
        out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        c = 0;
        while ((if8.busy !== 1'b0 || if7.busy !== 1'b0) && c < 2000) begin
            if (rnd) out_ready = 1'($urandom_range(0, 1));
            tick();
            c++;
        end
        if (c >= 2000) begin
            checks++; errors++;
            $display("FAIL stream_timeout: busy still high after 2000 cycles, expected 0");
        end
        out_ready = 1'b1;
    endtask

    task automatic check_iv_stream();
        check("iv_count", 0, 32'(rx8.size()), 32'd32);
        check("iv_count", 1, 32'(rx7.size()), 32'd28);
        for (int i = 0; i < 32; i++)
            check("iv_byte", 0, 32'(rx8[i]), 32'(8'(iv[i / 4] >> (8 * (3 - i % 4)))));
        for (int i = 0; i < 28; i++)
            check("iv_byte", 1, 32'(rx7[i]), 32'(8'(iv[i / 4] >> (8 * (3 - i % 4)))));
    endtask

    initial begin
        int d8, d7, b8, b7, c;
        logic [7:0] acc;

        rst = 1'b0;
        tick(); tick();
        rst = 1'b1;
        check("rst_valid", 0, 32'(if8.out_valid), 32'd0);
        check("rst_busy",  0, 32'(if8.busy),      32'd0);
        check("rst_done",  0, 32'(if8.done),      32'd0);
        check("rst_data",  0, 32'(if8.out_data),  32'd0);

        // Address 7 is out of range for the 7-word instance.
        for (int i = 0; i < 8; i++) wr(3'(i), iv[i]);

        rx8.delete(); rx7.delete();
        out_ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        d8 = 0; d7 = 0;
        for (int k = 1; k <= 40; k++) begin
            if (if8.done === 1'b1 && d8 == 0) d8 = k;
            if (if7.done === 1'b1 && d7 == 0) d7 = k;
            tick();
        end
        check("done_cycle", 0, 32'(d8), 32'd33);
        check("done_cycle", 1, 32'(d7), 32'd29);
        check("first_byte", 0, 32'(rx8[0]), 32'h6a);
        check("byte3",      0, 32'(rx8[3]), 32'h67);
        check("byte4",      0, 32'(rx8[4]), 32'hbb);
        check("last_byte",  0, 32'(rx8[31]), 32'h19);
        check("last_byte",  1, 32'(rx7[27]), 32'hab);
        check("busy_after", 0, 32'(if8.busy), 32'd0);
        check_iv_stream();

        run_stream(1'b1);
        check_iv_stream();

        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (10) tick();
        wr(3'd0, 32'hdeadbeef);
        wait_idle(100);
        run_stream(1'b0);
        check_iv_stream();

        rx8.delete(); rx7.delete();
        wr_en = 1'b1; wr_addr = 3'd0; wr_data = 32'h01020304; start = 1'b1;
        tick();
        wr_en = 1'b0; start = 1'b0;
        wait_idle(100);
        for (int i = 0; i < 4; i++) begin
            check("same_cycle_wr", 0, 32'(rx8[i]), 32'(i + 1));
            check("same_cycle_wr", 1, 32'(rx7[i]), 32'(i + 1));
        end

        b8 = done_cnt[0]; b7 = done_cnt[1];
        rx8.delete(); rx7.delete();
        start = 1'b1;
        c = 0;
        while (if8.done !== 1'b1 && c < 100) begin
            tick();
            c++;
        end
        tick(); tick();
        start = 1'b0;
        wait_idle(200);
        check("held_start_dones", 0, 32'(done_cnt[0] - b8), 32'd2);
        check("held_start_dones", 1, 32'(done_cnt[1] - b7), 32'd2);
        check("held_start_bytes", 0, 32'(rx8.size()), 32'd64);
        check("held_start_bytes", 1, 32'(rx7.size()), 32'd56);

        repeat (3) begin
            for (int k = 0; k < 8; k++) wr(3'($urandom_range(0, 7)), $urandom);
            run_stream(1'b1);
            check("rand_count", 0, 32'(rx8.size()), 32'd32);
            check("rand_count", 1, 32'(rx7.size()), 32'd28);
        end

        b8 = done_cnt[0]; b7 = done_cnt[1];
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (10) tick();
        rst = 1'b0;
        tick(); tick();
        rst = 1'b1;
        check("midrst_valid", 0, 32'(if8.out_valid), 32'd0);
        check("midrst_busy",  0, 32'(if8.busy),      32'd0);
        check("midrst_done",  1, 32'(if7.done),      32'd0);
        check("midrst_no_done", 0, 32'(done_cnt[0] - b8), 32'd0);
        check("midrst_no_done", 1, 32'(done_cnt[1] - b7), 32'd0);
        run_stream(1'b0);
        acc = '0;
        foreach (rx8[i]) acc = acc | rx8[i];
        check("zero_count",  0, 32'(rx8.size()), 32'd32);
        check("zero_stream", 0, 32'(acc), 32'd0);

        tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete within 500000 time units");
        $fatal(1);
    end

endmodule

// File: doc/digest_serializer_32to8b.md
Name: digest_serializer_32to8b

Overview:
- Word-in, byte-out buffer for the SHA-256 datapath; the mirror of the byte-in, word-out message register file.
- The hash core writes the final digest words (H0..H7) through a 32-bit write port.
- On start, the block streams the digest out as bytes, big-endian, over a valid/ready handshake.
- It sits between the compression core and the byte-wide host/output interface.

Parameters:
- NUM_WORDS, 8, number of 32-bit digest words held and streamed (8 = SHA-256; 7 = SHA-224).
- CNT_W, 5, byte counter width; must satisfy 2^CNT_W >= NUM_WORDS*4.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-low reset (rst=0 resets on the next rising clk edge).
- wr_en  input  1  word write strobe.
- wr_addr  input  3  word index, 0..NUM_WORDS-1.
- wr_data  input  32  digest word.
- start  input  1  begin streaming; 1-cycle pulse or level.
- out_data  output  8  current byte.
- out_valid  output  1  out_data is valid.
- out_ready  input  1  consumer accepts byte.
- busy  output  1  high in SEND and DONE states.
- done  output  1  1-cycle pulse after the last byte is accepted.

Behaviour:
- Storage: NUM_WORDS x 32-bit registers.
- Reset (rst=0): all words cleared to 0, state=IDLE, byte_cnt=0, out_valid=0, out_data=0, busy=0, done=0.
- Writes:
  - Accepted only in IDLE with wr_en=1 and wr_addr<NUM_WORDS.
  - Ignored when wr_addr>=NUM_WORDS.
  - Ignored in SEND and DONE; storage stays frozen while streaming.
- FSM states: IDLE, SEND, DONE.
- IDLE:
  - start=1 -> SEND, byte_cnt=0.
  - A write in the same cycle as start commits at the same edge, so it is included in the stream.
- SEND:
  - out_valid=1.
  - out_data = byte (byte_cnt mod 4) of word (byte_cnt / 4), MSB first: byte 0 is word0[31:24], byte 3 is word0[7:0], byte 4 is word1[31:24], and so on.
  - out_data is combinational from storage and byte_cnt; it is stable while out_valid=1 and out_ready=0.
  - Handshake fires when out_valid and out_ready are both 1 at a rising edge.
  - On a handshake: byte_cnt increments; if byte_cnt = NUM_WORDS*4-1, go to DONE and clear byte_cnt to 0.
  - No handshake: hold state and byte_cnt. out_ready may toggle arbitrarily.
- DONE: done=1, out_valid=0, busy=1 for exactly one cycle, then IDLE.
- start is ignored in SEND and DONE; a held start relaunches only once back in IDLE.
- Throughput: 1 byte/cycle with out_ready tied high.
- Latency: start edge to first out_valid = 1 cycle; 32 bytes + 1 DONE cycle for NUM_WORDS=8.
- out_data = 0 whenever out_valid=0.
- Reset mid-stream: abort immediately to reset values; no done pulse; storage is cleared.

Decomposition:
- Shared sha256 package:
  - state encoding constants ST_IDLE=2'd0, ST_SEND=2'd1, ST_DONE=2'd2;
  - DIGEST_WORDS=8 and BYTES_PER_WORD=4 constants.
- No sub-module needed; the byte mux is a case on byte_cnt[1:0] over the word selected by byte_cnt[CNT_W-1:2].

Test Plan:
- Reset: rst=0 for 2 cycles mid-stream -> out_valid=0, busy=0, done=0; a subsequent stream with no writes outputs 32 bytes of 0x00.
- Full stream: write words 0x6a09e667, 0xbb67ae85, 0x3c6ef372, 0xa54ff53a, 0x510e527f, 0x9b05688c, 0x1f83d9ab, 0x5be0cd19; start; out_ready=1 -> bytes 6a 09 e6 67 bb ... 19 on 32 consecutive cycles, done high on cycle 33, busy low after.
- Backpressure: same data, out_ready random 50% -> identical 32-byte sequence; out_data stable while stalled; byte count matches handshake count.
- Write during SEND: wr_en with word0=0xdeadbeef mid-stream -> ignored; the next stream still emits 6a 09 e6 67 first.
- Simultaneous start and write: in IDLE write word0=0x01020304 with start=1 in the same cycle -> first bytes are 01 02 03 04.
- start held high through DONE -> exactly one new stream starts after returning to IDLE; out-of-range wr_addr=7 with NUM_WORDS=7 -> no storage change, 28 bytes per stream.
